// File: rtl/bp_history_recovery_ctrl_pkg.sv
// Shared types for the gshare global-history recovery controller:
// controller state, checkpoint entry layout and the recovered-GHR helper.
package bp_history_recovery_ctrl_pkg;

    localparam int BPRED_WIDTH        = 9;
    localparam int DEPTH_DEF          = 4;
    localparam int RECOVER_CYCLES_DEF = 1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic [BPRED_WIDTH-1:0] ghr;
        logic                   prediction;
    } checkpoint_t;

    localparam int ENTRY_W = $bits(checkpoint_t);

    // Rebuild the history as if the branch had been predicted correctly.
    function automatic logic [BPRED_WIDTH-1:0] recovered_ghr(input checkpoint_t cp,
                                                             input logic outcome);
        return {cp.ghr[BPRED_WIDTH-2:0], outcome};
    endfunction

endpackage

// File: rtl/bp_history_recovery_ctrl_if.sv
// Pipeline-side bundle for the history recovery controller: DEC/EX branch
// events in, GHR shift/load controls and status out.
interface bp_history_recovery_ctrl_if
    import bp_history_recovery_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   dec_is_branch;
    logic                   prediction;
    logic [BPRED_WIDTH-1:0] global_history;
    logic                   alu_branch_valid;
    logic                   alu_branch_outcome;

    logic                   ghr_shift_en;
    logic                   ghr_shift_bit;
    logic                   ghr_load_en;
    logic [BPRED_WIDTH-1:0] ghr_load_value;
    logic                   mispredict;
    logic                   stall_dec;
    logic [CNT_W-1:0]       inflight_count;
    logic                   underflow;

    modport master (
        output dec_is_branch, prediction, global_history,
               alu_branch_valid, alu_branch_outcome,
        input  ghr_shift_en, ghr_shift_bit, ghr_load_en, ghr_load_value,
               mispredict, stall_dec, inflight_count, underflow
    );

    modport slave (
        input  dec_is_branch, prediction, global_history,
               alu_branch_valid, alu_branch_outcome,
        output ghr_shift_en, ghr_shift_bit, ghr_load_en, ghr_load_value,
               mispredict, stall_dec, inflight_count, underflow
    );

endinterface

// File: rtl/bp_history_recovery_ctrl_checkpoint_fifo.sv
// Circular checkpoint buffer: one entry per predicted, unresolved branch.
// Head is read combinationally; clear wins over push and pop.
module bp_history_recovery_ctrl_checkpoint_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[tail_ptr] <= push_data;
    end

    assign head_data = mem[head_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/bp_history_recovery_ctrl.sv
// Global history recovery controller: checkpoints the GHR per predicted branch,
// checks EX resolutions in order and reloads the GHR on a mispredict.
//
// state   | meaning
// RUN     | normal operation, DEC branches checkpointed and shifted in
// RECOVER | wrong-path window after a mispredict, DEC branches ignored
module bp_history_recovery_ctrl
    import bp_history_recovery_ctrl_pkg::*;
#(
    parameter int DEPTH          = DEPTH_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    bp_history_recovery_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES + 1) : 1;

    ctrl_state_t      state, state_nxt;
    logic [RC_W-1:0]  rcnt, rcnt_nxt;

    checkpoint_t      head_cp;
    checkpoint_t      new_cp;
    logic [ENTRY_W-1:0] head_data;
    logic             full, empty;
    logic [CNT_W-1:0] count;

    logic             push, pop, mispredict, stall;
    logic             underflow;

    assign new_cp.ghr        = bus.global_history;
    assign new_cp.prediction = bus.prediction;
    assign head_cp           = checkpoint_t'(head_data);

    bp_history_recovery_ctrl_checkpoint_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (mispredict),
        .push_data (new_cp),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        if (mispredict) begin
            if (RECOVER_CYCLES == 0) begin
                state_nxt = RUN;
            end else begin
                state_nxt = RECOVER;
                rcnt_nxt  = RC_W'(RECOVER_CYCLES);
            end
        end else if (state == RECOVER) begin
            if (rcnt <= RC_W'(1)) begin
                state_nxt = RUN;
                rcnt_nxt  = '0;
            end else begin
                rcnt_nxt = rcnt - RC_W'(1);
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO only stalls without one.
    always_comb begin
        pop        = bus.alu_branch_valid & ~empty;
        mispredict = pop & (head_cp.prediction != bus.alu_branch_outcome);
        stall      = full & bus.dec_is_branch & ~pop;
        push       = bus.dec_is_branch & (state == RUN) & (~full | pop) & ~mispredict;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (bus.alu_branch_valid && empty) begin
            underflow <= 1'b1;
        end
    end

    assign bus.ghr_shift_en   = push;
    assign bus.ghr_shift_bit  = bus.prediction;
    assign bus.ghr_load_en    = mispredict;
    assign bus.ghr_load_value = recovered_ghr(head_cp, bus.alu_branch_outcome);
    assign bus.mispredict     = mispredict;
    assign bus.stall_dec      = stall;
    assign bus.inflight_count = count;
    assign bus.underflow      = underflow;

endmodule

// File: tb/tb_bp_history_recovery_ctrl.sv
// Directed bench for the history recovery controller with a behavioural GHR
// attached to its shift/load controls.
module tb_bp_history_recovery_ctrl;
    import bp_history_recovery_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [BPRED_WIDTH-1:0] ghr;
    logic                   ghr_set = 1'b0;
    logic [BPRED_WIDTH-1:0] ghr_set_val = '0;

    bp_history_recovery_ctrl_if #(.DEPTH(4)) bus ();

    bp_history_recovery_ctrl #(
        .DEPTH          (4),
        .RECOVER_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Global history register: load beats shift, bench preset beats both.
    always @(posedge clk or posedge rst) begin
        if (rst)                   ghr <= '0;
        else if (ghr_set)          ghr <= ghr_set_val;
        else if (bus.ghr_load_en)  ghr <= bus.ghr_load_value;
        else if (bus.ghr_shift_en) ghr <= {ghr[BPRED_WIDTH-2:0], bus.ghr_shift_bit};
    end

    assign bus.global_history = ghr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dec, input logic pred, input logic valid, input logic outc);
        bus.dec_is_branch      = dec;
        bus.prediction         = pred;
        bus.alu_branch_valid   = valid;
        bus.alu_branch_outcome = outc;
        #1;
    endtask

    task automatic preset_ghr(input logic [BPRED_WIDTH-1:0] v);
        ghr_set     = 1'b1;
        ghr_set_val = v;
        tick();
        ghr_set     = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        tick();
        tick();
        chk("rst_count",     32'(bus.inflight_count), 0);
        chk("rst_shift",     32'(bus.ghr_shift_en),   0);
        chk("rst_load",      32'(bus.ghr_load_en),    0);
        chk("rst_mispred",   32'(bus.mispredict),     0);
        chk("rst_stall",     32'(bus.stall_dec),      0);
        chk("rst_underflow", 32'(bus.underflow),      0);
        rst = 1'b0;
        tick();

        // Correct prediction
        preset_ghr(9'h001);
        drive(1, 0, 0, 0);
        chk("t2_shift_en",  32'(bus.ghr_shift_en),  1);
        chk("t2_shift_bit", 32'(bus.ghr_shift_bit), 0);
        chk("t2_no_load",   32'(bus.ghr_load_en),   0);
        tick();
        chk("t2_ghr",   32'(ghr),                32'h002);
        chk("t2_count", 32'(bus.inflight_count), 1);
        drive(0, 0, 1, 0);
        chk("t2_res_mispred", 32'(bus.mispredict),  0);
        chk("t2_res_load",    32'(bus.ghr_load_en), 0);
        tick();
        drive(0, 0, 0, 0);
        chk("t2_count_after", 32'(bus.inflight_count), 0);
        chk("t2_ghr_after",   32'(ghr),                32'h002);

        // Mispredict and wrong-path window
        preset_ghr(9'h001);
        drive(1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0);
        tick();
        chk("t3_ghr_spec", 32'(ghr),                32'h005);
        chk("t3_count2",   32'(bus.inflight_count), 2);
        drive(0, 0, 1, 1);
        chk("t3_mispred",    32'(bus.mispredict),     1);
        chk("t3_load_en",    32'(bus.ghr_load_en),    1);
        chk("t3_load_value", 32'(bus.ghr_load_value), 32'h003);
        tick();
        chk("t3_ghr_loaded", 32'(ghr),                32'h003);
        chk("t3_count0",     32'(bus.inflight_count), 0);
        drive(1, 1, 0, 0);
        chk("t3_recover_no_shift", 32'(bus.ghr_shift_en), 0);
        tick();
        chk("t3_ghr_hold",   32'(ghr),                32'h003);
        chk("t3_count_hold", 32'(bus.inflight_count), 0);
        chk("t3_run_shift",  32'(bus.ghr_shift_en),   1);
        drive(0, 0, 0, 0);

        // Fill to DEPTH, stall, then push+pop through a full FIFO
        drive(1, 1, 0, 0); tick();
        drive(1, 0, 0, 0); tick();
        drive(1, 1, 0, 0); tick();
        drive(1, 0, 0, 0); tick();
        chk("t4_count4", 32'(bus.inflight_count), 4);
        chk("t4_ghr",    32'(ghr),                32'h03A);
        drive(1, 1, 0, 0);
        chk("t4_stall",    32'(bus.stall_dec),    1);
        chk("t4_no_shift", 32'(bus.ghr_shift_en), 0);
        tick();
        chk("t4_count_stall", 32'(bus.inflight_count), 4);
        chk("t4_ghr_stall",   32'(ghr),                32'h03A);
        drive(1, 1, 1, 1);
        chk("t4_pp_stall",   32'(bus.stall_dec),    0);
        chk("t4_pp_shift",   32'(bus.ghr_shift_en), 1);
        chk("t4_pp_mispred", 32'(bus.mispredict),   0);
        tick();
        chk("t4_pp_count", 32'(bus.inflight_count), 4);
        chk("t4_pp_ghr",   32'(ghr),                32'h075);

        // Mispredict with a concurrent DEC branch: load only
        drive(1, 0, 1, 1);
        chk("t5_mispred",    32'(bus.mispredict),     1);
        chk("t5_no_shift",   32'(bus.ghr_shift_en),   0);
        chk("t5_load_value", 32'(bus.ghr_load_value), 32'h00F);
        tick();
        chk("t5_ghr",   32'(ghr),                32'h00F);
        chk("t5_count", 32'(bus.inflight_count), 0);
        drive(1, 0, 0, 0);
        chk("t5_recover_no_shift", 32'(bus.ghr_shift_en), 0);
        tick();
        chk("t5_ghr_hold",  32'(ghr),              32'h00F);
        chk("t5_run_shift", 32'(bus.ghr_shift_en), 1);
        drive(0, 0, 0, 0);

        // Resolution with an empty FIFO
        drive(0, 0, 1, 0);
        chk("t6_no_load",    32'(bus.ghr_load_en), 0);
        chk("t6_no_mispred", 32'(bus.mispredict),  0);
        tick();
        drive(0, 0, 0, 0);
        chk("t6_underflow", 32'(bus.underflow),      1);
        chk("t6_count",     32'(bus.inflight_count), 0);
        chk("t6_ghr",       32'(ghr),                32'h00F);
        tick();
        chk("t6_underflow_sticky", 32'(bus.underflow), 1);

        // Asynchronous reset with two branches in flight
        drive(1, 1, 0, 0); tick();
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0);
        chk("t1_count2", 32'(bus.inflight_count), 2);
        chk("t1_ghr",    32'(ghr),                32'h03E);
        rst = 1'b1;
        #1;
        chk("t1_count0",    32'(bus.inflight_count), 0);
        chk("t1_underflow", 32'(bus.underflow),      0);
        chk("t1_load",      32'(bus.ghr_load_en),    0);
        chk("t1_shift",     32'(bus.ghr_shift_en),   0);
        chk("t1_stall",     32'(bus.stall_dec),      0);
        rst = 1'b0;
        #1;
        drive(1, 1, 0, 0);
        chk("t1_run_shift", 32'(bus.ghr_shift_en), 1);
        tick();
        drive(0, 0, 0, 0);
        chk("t1_count1", 32'(bus.inflight_count), 1);
        chk("t1_ghr1",   32'(ghr),                32'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
